gpc311_bist: RTL and testbench

Synthesizable built-in self-test controller for the `gpc311_4` generalized parallel counter, which counts column weights 1/2/4 as 1+1+3 bits to 4 bits. It drives the DUT's `src0`/`src1`/`src2` inputs and reads back its `dst` output. It sweeps all 32 input vectors at one vector per cycle and checks each `dst` against the weighted sum, with support for a pipelined DUT. It reports pass/fail, a saturating mismatch count and the first failing vector. It sits beside a `gpc311_4` instance in on-chip test wrappers and in the FPGA regression harness.

---
 rtl/gpc311_bist.sv | 204 ++++++++++++++++++++
 tb/tb_gpc311_bist.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpc311_bist.sv
// gpc311_bist: built-in self-test controller for a gpc311_4 generalized
// parallel counter (weights 1, 2, 4x3 summed into a 4-bit result).
// Sweeps all 32 input vectors, one per cycle, and checks the DUT result
// against the weighted sum. A delay line of PIPE_LAT stages aligns the
// expected value with a pipelined DUT.
module gpc311_bist #(
    parameter int PIPE_LAT = 0,
    parameter int ERR_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             src0,
    output logic             src1,
    output logic [2:0]       src2,
    input  logic [3:0]       dst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [4:0]       first_err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last drain counter value before moving on to DONE.
    localparam int          DRAIN_LAST_I = (PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0;
    localparam logic [1:0]  DRAIN_LAST   = 2'(DRAIN_LAST_I);
    localparam logic [4:0]  VEC_LAST     = 5'd31;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Weighted column sum: bit 0 weight 1, bit 1 weight 2, bits 2..4 weight 4.
    // The sum of three weight-4 bits is at most 3, so 4 bits never overflow.
    function automatic logic [3:0] gpc_sum(input logic [4:0] v);
        logic [1:0] w4_cnt;
        w4_cnt  = {1'b0, v[2]} + {1'b0, v[3]} + {1'b0, v[4]};
        gpc_sum = {w4_cnt, 2'b00} + {2'b00, v[1], 1'b0} + {3'b000, v[0]};
    endfunction

    state_t            state_r, state_nxt;
    logic [4:0]        vec_r, vec_nxt;
    logic [1:0]        drain_r, drain_nxt;
    logic [ERR_W-1:0]  err_cnt_r, err_cnt_nxt;
    logic              fe_valid_r, fe_valid_nxt;
    logic [4:0]        fe_vec_r, fe_vec_nxt;
    logic              busy_r, done_r, pass_r;

    logic              valid_in_s;
    logic [3:0]        exp_s;
    logic              chk_valid_s;
    logic [3:0]        chk_exp_s;
    logic [4:0]        chk_vec_s;
    logic              mismatch_s;

    assign valid_in_s = (state_r == ST_RUN);
    assign exp_s      = gpc_sum(vec_r);

    generate
        if (PIPE_LAT == 0) begin : g_nopipe
            assign chk_valid_s = valid_in_s;
            assign chk_exp_s   = exp_s;
            assign chk_vec_s   = vec_r;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0] vld_r;
            logic [3:0]          exp_r  [PIPE_LAT];
            logic [4:0]          vecd_r [PIPE_LAT];

            // Delay valid, expected sum and vector to line up with the DUT output.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_r <= {PIPE_LAT{1'b0}};
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        exp_r[i]  <= 4'd0;
                        vecd_r[i] <= 5'd0;
                    end
                end else begin
                    vld_r[0]  <= valid_in_s;
                    exp_r[0]  <= exp_s;
                    vecd_r[0] <= vec_r;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        vld_r[i]  <= vld_r[i-1];
                        exp_r[i]  <= exp_r[i-1];
                        vecd_r[i] <= vecd_r[i-1];
                    end
                end
            end

            assign chk_valid_s = vld_r[PIPE_LAT-1];
            assign chk_exp_s   = exp_r[PIPE_LAT-1];
            assign chk_vec_s   = vecd_r[PIPE_LAT-1];
        end
    endgenerate

    assign mismatch_s = chk_valid_s && (dst != chk_exp_s);

    // Next-state, vector sequencing and result accumulation.
    always_comb begin
        state_nxt    = state_r;
        vec_nxt      = vec_r;
        drain_nxt    = drain_r;
        err_cnt_nxt  = err_cnt_r;
        fe_valid_nxt = fe_valid_r;
        fe_vec_nxt   = fe_vec_r;

        // Result update from the aligned compare; only active in RUN/DRAIN
        // because the delayed valid bit is zero everywhere else.
        if (mismatch_s) begin
            if (err_cnt_r != ERR_MAX) begin
                err_cnt_nxt = err_cnt_r + ERR_ONE;
            end else begin
                err_cnt_nxt = err_cnt_r;
            end
            if (!fe_valid_r) begin
                fe_valid_nxt = 1'b1;
                fe_vec_nxt   = chk_vec_s;
            end else begin
                fe_valid_nxt = fe_valid_r;
            end
        end else begin
            err_cnt_nxt = err_cnt_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt    = ST_RUN;
                    vec_nxt      = 5'd0;
                    drain_nxt    = 2'd0;
                    err_cnt_nxt  = {ERR_W{1'b0}};
                    fe_valid_nxt = 1'b0;
                    fe_vec_nxt   = 5'd0;
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_RUN: begin
                if (vec_r == VEC_LAST) begin
                    drain_nxt = 2'd0;
                    if (PIPE_LAT > 0) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    vec_nxt = vec_r + 5'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    state_nxt = ST_DONE;
                end else begin
                    drain_nxt = drain_r + 2'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, vector and result registers, plus registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            vec_r      <= 5'd0;
            drain_r    <= 2'd0;
            err_cnt_r  <= {ERR_W{1'b0}};
            fe_valid_r <= 1'b0;
            fe_vec_r   <= 5'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            vec_r      <= vec_nxt;
            drain_r    <= drain_nxt;
            err_cnt_r  <= err_cnt_nxt;
            fe_valid_r <= fe_valid_nxt;
            fe_vec_r   <= fe_vec_nxt;
            busy_r     <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
            done_r     <= (state_nxt == ST_DONE);
            pass_r     <= (state_nxt == ST_DONE) && (err_cnt_nxt == {ERR_W{1'b0}});
        end
    end

    // The vector register drives the DUT inputs directly.
    assign src0            = vec_r[0];
    assign src1            = vec_r[1];
    assign src2            = vec_r[4:2];
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_cnt         = err_cnt_r;
    assign first_err_valid = fe_valid_r;
    assign first_err_vec   = fe_vec_r;

endmodule

// File: tb/tb_gpc311_bist.sv
// Testbench for gpc311_bist: four controller instances (combinational DUT
// with selectable fault, 2-stage DUT at PIPE_LAT 2 and 1, saturating ERR_W=3)
// with a scoreboard of issued vectors and bench-computed sweep results.
module tb_gpc311_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] start_v = 4'd0;
    int         a_mode = 0;   // 0 good, 1 dst[0] stuck at 0, 2 dst forced 0xF

    // instance outputs
    logic       s0 [4];
    logic       s1 [4];
    logic [2:0] s2 [4];
    logic [3:0] dst_v [4];
    logic       busy_v [4];
    logic       done_v [4];
    logic       pass_v [4];
    logic       fev_v [4];
    logic [4:0] fe_vec_v [4];
    logic [5:0] err_a, err_b, err_c;
    logic [2:0] err_d;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] sb_q[$];

    function automatic logic [3:0] ref_sum(input logic [4:0] v);
        int s;
        s = int'(v[0]) + 2 * int'(v[1]) + 4 * (int'(v[2]) + int'(v[3]) + int'(v[4]));
        return 4'(s);
    endfunction

    function automatic logic [3:0] fault_model(input int mode, input logic [4:0] v);
        logic [3:0] d;
        d = ref_sum(v);
        if (mode == 1) d = d & 4'hE;
        if (mode == 2) d = 4'hF;
        return d;
    endfunction

    // combinational DUT for instance A
    always_comb dst_v[0] = fault_model(a_mode, {s2[0], s1[0], s0[0]});

    // two-stage pipelined DUT models for instances B and C
    logic [3:0] b_p1 = 4'd0, b_p2 = 4'd0, c_p1 = 4'd0, c_p2 = 4'd0;
    always @(posedge clk) begin
        b_p1 <= ref_sum({s2[1], s1[1], s0[1]});
        b_p2 <= b_p1;
        c_p1 <= ref_sum({s2[2], s1[2], s0[2]});
        c_p2 <= c_p1;
    end
    assign dst_v[1] = b_p2;
    assign dst_v[2] = c_p2;
    assign dst_v[3] = 4'hF;

    gpc311_bist #(.PIPE_LAT(0), .ERR_W(6)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .src0(s0[0]), .src1(s1[0]), .src2(s2[0]), .dst(dst_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_a),
        .first_err_valid(fev_v[0]), .first_err_vec(fe_vec_v[0]));
    gpc311_bist #(.PIPE_LAT(2), .ERR_W(6)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .src0(s0[1]), .src1(s1[1]), .src2(s2[1]), .dst(dst_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_b),
        .first_err_valid(fev_v[1]), .first_err_vec(fe_vec_v[1]));
    gpc311_bist #(.PIPE_LAT(1), .ERR_W(6)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .src0(s0[2]), .src1(s1[2]), .src2(s2[2]), .dst(dst_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_c),
        .first_err_valid(fev_v[2]), .first_err_vec(fe_vec_v[2]));
    gpc311_bist #(.PIPE_LAT(0), .ERR_W(3)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]),
        .src0(s0[3]), .src1(s1[3]), .src2(s2[3]), .dst(dst_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_cnt(err_d),
        .first_err_valid(fev_v[3]), .first_err_vec(fe_vec_v[3]));

    function automatic logic [5:0] err_of(input int s);
        case (s)
            0:       return err_a;
            1:       return err_b;
            2:       return err_c;
            default: return {3'b000, err_d};
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input int s);
        check_val("rst_src", {27'd0, s2[s], s1[s], s0[s]}, 32'd0);
        check_val("rst_busy", {31'd0, busy_v[s]}, 32'd0);
        check_val("rst_done", {31'd0, done_v[s]}, 32'd0);
        check_val("rst_pass", {31'd0, pass_v[s]}, 32'd0);
        check_val("rst_err", {26'd0, err_of(s)}, 32'd0);
        check_val("rst_fev", {31'd0, fev_v[s]}, 32'd0);
        check_val("rst_fevec", {27'd0, fe_vec_v[s]}, 32'd0);
    endtask

    // Expected error count / first failing vector for a combinational fault.
    task automatic model_sweep(input int mode, input int err_w, output int e_err,
                               output logic [4:0] e_fev, output logic e_fevv);
        e_err = 0; e_fev = 5'd0; e_fevv = 1'b0;
        for (int v = 0; v < 32; v++) begin
            if (fault_model(mode, 5'(v)) != ref_sum(5'(v))) begin
                if (e_err < (1 << err_w) - 1) e_err++;
                if (!e_fevv) begin e_fevv = 1'b1; e_fev = 5'(v); end
            end
        end
    endtask

    // One sweep on instance s. exp_err < 0 means "any nonzero count".
    task automatic sweep(input int s, input int lat, input int exp_err, input logic [4:0] exp_fev,
                         input logic exp_fevv, input bit pulses, input bit abort);
        logic [4:0] ev;
        sb_q.delete();
        for (int v = 0; v < 32; v++) sb_q.push_back(5'(v));
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        for (int c = 0; c <= 32 + lat; c++) begin
            if (c > 0) begin @(posedge clk); #1; start_v[s] = 1'b0; end
            if (c == 0) begin
                check_val("clr_err", {26'd0, err_of(s)}, 32'd0);
                check_val("clr_fev", {31'd0, fev_v[s]}, 32'd0);
            end
            if (c < 32) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_empty", 32'd1, 32'd0);
                end else begin
                    ev = sb_q.pop_front();
                    check_val("src_vec", {27'd0, s2[s], s1[s], s0[s]}, {27'd0, ev});
                end
            end
            check_val("busy", {31'd0, busy_v[s]}, {31'd0, (c < 32 + lat)});
            check_val("done", {31'd0, done_v[s]}, {31'd0, (c == 32 + lat)});
            if (pulses && (c == 5 || c == 20)) start_v[s] = 1'b1;
            if (abort && c == 10) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check_all_zero(s);
                rst_n = 1'b1;
                @(posedge clk); #1;
                check_val("post_rst_busy", {31'd0, busy_v[s]}, 32'd0);
                return;
            end
        end
        check_val("sb_drained", sb_q.size(), 32'd0);
        if (exp_err < 0) begin
            check_val("err_nonzero", {31'd0, err_of(s) != 6'd0}, 32'd1);
            check_val("pass", {31'd0, pass_v[s]}, 32'd0);
        end else begin
            check_val("err_cnt", {26'd0, err_of(s)}, exp_err);
            check_val("pass", {31'd0, pass_v[s]}, {31'd0, (exp_err == 0)});
            check_val("fe_valid", {31'd0, fev_v[s]}, {31'd0, exp_fevv});
            check_val("fe_vec", {27'd0, fe_vec_v[s]}, {27'd0, exp_fev});
        end
        // results stay stable in DONE
        @(posedge clk); #1;
        check_val("done_hold", {31'd0, done_v[s]}, 32'd1);
        check_val("src_hold", {27'd0, s2[s], s1[s], s0[s]}, 32'd31);
        if (exp_err >= 0) check_val("err_hold", {26'd0, err_of(s)}, exp_err);
    endtask

    initial begin
        int         e_err;
        logic [4:0] e_fev;
        logic       e_fevv;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) check_all_zero(s);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // clean combinational sweep
        a_mode = 0;
        model_sweep(0, 6, e_err, e_fev, e_fevv);
        sweep(0, 0, e_err, e_fev, e_fevv, 1'b0, 1'b0);
        // restart from DONE with start pulses during the sweep
        sweep(0, 0, e_err, e_fev, e_fevv, 1'b1, 1'b0);

        // stuck-at-0 on dst[0]
        a_mode = 1;
        model_sweep(1, 6, e_err, e_fev, e_fevv);
        check_val("model_stuck_cnt", e_err, 32'd16);
        sweep(0, 0, e_err, e_fev, e_fevv, 1'b0, 1'b0);

        // restart after failing sweep with a good DUT
        a_mode = 0;
        model_sweep(0, 6, e_err, e_fev, e_fevv);
        sweep(0, 0, e_err, e_fev, e_fevv, 1'b0, 1'b0);

        // reset mid-sweep, then a full clean sweep
        sweep(0, 0, 0, 5'd0, 1'b0, 1'b0, 1'b1);
        sweep(0, 0, e_err, e_fev, e_fevv, 1'b0, 1'b0);

        // pipelined DUT, matched and mismatched latency
        sweep(1, 2, 0, 5'd0, 1'b0, 1'b0, 1'b0);
        sweep(2, 1, -1, 5'd0, 1'b0, 1'b0, 1'b0);

        // saturation with ERR_W = 3
        model_sweep(2, 3, e_err, e_fev, e_fevv);
        sweep(3, 0, e_err, e_fev, e_fevv, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
